// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: command stage in front of a JK flip-flop.
// Commands {op,cnt} are accepted over valid/ready into a small FIFO. Each one
// is replayed onto registered J/K outputs for cnt+1 cycles. Back-to-back
// commands issue with no idle cycle between them.
// Optional build macro JK_SEQ_SHADOW_EN adds a shadow model of the flip-flop
// output (q_model) and a sticky divergence flag against the real q (mismatch).
module jk_cmd_sequencer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [1:0]       in_op,
   input  logic [CNT_W-1:0] in_cnt,
   output logic             in_ready,
   output logic             J,
   output logic             K,
   output logic             busy,
   output logic             cmd_done
`ifdef JK_SEQ_SHADOW_EN
   ,
   input  logic             q_fb,
   output logic             q_model,
   output logic             mismatch
`endif
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   // FIFO storage and pointers; pointers carry one extra wrap bit
   logic [CNT_W+1:0] mem [DEPTH];
   logic [PTR_W:0]   wr_ptr_reg, wr_ptr_next;
   logic [PTR_W:0]   rd_ptr_reg, rd_ptr_next;
   logic             full, empty, push, pop;
   logic [1:0]       head_op;
   logic [CNT_W-1:0] head_cnt;

   // Executor state
   state_t           state_reg, state_next;
   logic [1:0]       op_reg, op_next;
   logic [CNT_W-1:0] rem_reg, rem_next;
   logic             j_reg, j_next;
   logic             k_reg, k_next;
   logic             done_reg, done_next;

   assign empty    = (wr_ptr_reg == rd_ptr_reg);
   assign full     = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                     (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
   assign in_ready = reset && !full;
   assign push     = in_valid && in_ready;
   assign head_op  = mem[rd_ptr_reg[PTR_W-1:0]][CNT_W+1:CNT_W];
   assign head_cnt = mem[rd_ptr_reg[PTR_W-1:0]][CNT_W-1:0];

   assign J        = j_reg;
   assign K        = k_reg;
   assign busy     = (state_reg == ISSUE);
   assign cmd_done = done_reg;

   // FIFO write port; the entry is captured on every accepted push
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg[PTR_W-1:0]] <= {in_op, in_cnt};
      end
   end

   // Next-state, pop decision and next values of the registered J/K/done drives
   always_comb begin
      state_next = state_reg;
      op_next    = op_reg;
      rem_next   = rem_reg;
      pop        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               state_next = ISSUE;
               op_next    = head_op;
               rem_next   = head_cnt;
            end
         end
         ISSUE: begin
            if (rem_reg != '0) begin
               rem_next = rem_reg - CNT_W'(1);
            end else if (!empty) begin
               // Last cycle of this command: chain straight into the next one
               pop      = 1'b1;
               op_next  = head_op;
               rem_next = head_cnt;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      // op encoding maps directly: J = op[1], K = op[0] (hold gives 0/0)
      j_next      = (state_next == ISSUE) && op_next[1];
      k_next      = (state_next == ISSUE) && op_next[0];
      done_next   = (state_next == ISSUE) && (rem_next == '0);
      wr_ptr_next = wr_ptr_reg + {{PTR_W{1'b0}}, push};
      rd_ptr_next = rd_ptr_reg + {{PTR_W{1'b0}}, pop};
   end

   // State, pointer and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg  <= IDLE;
         op_reg     <= 2'b00;
         rem_reg    <= '0;
         j_reg      <= 1'b0;
         k_reg      <= 1'b0;
         done_reg   <= 1'b0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         state_reg  <= state_next;
         op_reg     <= op_next;
         rem_reg    <= rem_next;
         j_reg      <= j_next;
         k_reg      <= k_next;
         done_reg   <= done_next;
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
      end
   end

`ifdef JK_SEQ_SHADOW_EN
   logic q_model_reg;
   logic mismatch_reg;

   assign q_model  = q_model_reg;
   assign mismatch = mismatch_reg;

   // Shadow flip-flop follows the op being driven; divergence latches until reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         q_model_reg  <= 1'b0;
         mismatch_reg <= 1'b0;
      end else begin
         if (state_reg == ISSUE) begin
            case (op_reg)
               2'b01:   q_model_reg <= 1'b0;
               2'b10:   q_model_reg <= 1'b1;
               2'b11:   q_model_reg <= ~q_model_reg;
               default: q_model_reg <= q_model_reg;
            endcase
         end
         if (q_fb != q_model_reg) begin
            mismatch_reg <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: table-driven single commands, hand-written
// fill / wrap / reset sequences, and a scoreboard monitor that checks every
// issued cycle against the queue of accepted commands.
module tb_jk_cmd_sequencer;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             in_valid = 1'b0;
   logic [1:0]       in_op = 2'b00;
   logic [CNT_W-1:0] in_cnt = '0;
   logic             in_ready, J, K, busy, cmd_done;
`ifdef JK_SEQ_SHADOW_EN
   logic             q_fb, q_model, mismatch;
   logic             jk_q;
   logic             force_low = 1'b0;
   assign q_fb = force_low ? 1'b0 : jk_q;
`endif

   jk_cmd_sequencer #(.DEPTH(4), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_op    (in_op),
      .in_cnt   (in_cnt),
      .in_ready (in_ready),
      .J        (J),
      .K        (K),
      .busy     (busy),
      .cmd_done (cmd_done)
`ifdef JK_SEQ_SHADOW_EN
      ,
      .q_fb     (q_fb),
      .q_model  (q_model),
      .mismatch (mismatch)
`endif
   );

   always #5 clk = ~clk;

`ifdef JK_SEQ_SHADOW_EN
   // Reference JK flip-flop driven by the sequencer outputs
   always @(posedge clk) begin
      if (!reset) jk_q <= 1'b0;
      else begin
         case ({J, K})
            2'b01:   jk_q <= 1'b0;
            2'b10:   jk_q <= 1'b1;
            2'b11:   jk_q <= ~jk_q;
            default: jk_q <= jk_q;
         endcase
      end
   end
`endif

   typedef struct {
      logic [1:0]       op;
      logic [CNT_W-1:0] cnt;
   } cmd_t;

   typedef struct {
      logic [1:0]       op;
      logic [CNT_W-1:0] cnt;
      logic             ej;
      logic             ek;
   } vec_t;

   cmd_t exp_q[$];
   int   cur_len = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: got issue with empty scoreboard expected idle", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [CNT_W-1:0] cnt);
      in_valid = v;
      in_op    = op;
      in_cnt   = cnt;
   endtask

   // Scoreboard: accepted commands are queued at the edge, issued cycles popped
   always @(posedge clk) begin
      logic acc, rs;
      cmd_t c;
      rs    = reset;
      acc   = reset && in_valid && in_ready;
      c.op  = in_op;
      c.cnt = in_cnt;
      #1;
      if (!rs) begin
         exp_q.delete();
         cur_len = 0;
         chk("rst_outs", {J, K, busy, cmd_done}, 0);
      end else if (busy) begin
         if (exp_q.size() == 0) begin
            flag("spurious_issue");
         end else begin
            chk("mon_j", J, exp_q[0].op[1]);
            chk("mon_k", K, exp_q[0].op[0]);
            cur_len++;
            if (cmd_done) begin
               chk("mon_len", cur_len, int'(exp_q[0].cnt) + 1);
               void'(exp_q.pop_front());
               cur_len = 0;
            end else begin
               chk("mon_overrun", (cur_len <= int'(exp_q[0].cnt)), 1);
            end
         end
      end else begin
         chk("idle_outs", {J, K, cmd_done}, 0);
         chk("mon_abort", cur_len, 0);
      end
      if (acc) exp_q.push_back(c);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t vt[5];
      cmd_t fc[4];
      int   c0, n;

      vt[0] = '{op: 2'b10, cnt: 4'd2,  ej: 1'b1, ek: 1'b0};
      vt[1] = '{op: 2'b01, cnt: 4'd0,  ej: 1'b0, ek: 1'b1};
      vt[2] = '{op: 2'b11, cnt: 4'd1,  ej: 1'b1, ek: 1'b1};
      vt[3] = '{op: 2'b00, cnt: 4'd3,  ej: 1'b0, ek: 1'b0};
      vt[4] = '{op: 2'b10, cnt: 4'd15, ej: 1'b1, ek: 1'b0};

      // Reset held with in_valid asserted: nothing accepted, outputs quiet
      drive(1'b1, 2'b11, 4'd3);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_ready", in_ready, 0);
         chk("rst_jkb", {J, K, busy}, 0);
      end
      reset = 1'b1;
      drive(1'b0, 2'b00, 4'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_rst_busy", busy, 0);
         chk("post_rst_ready", in_ready, 1);
      end

      // Single commands into an idle sequencer, cycle-exact
      for (int v = 0; v < 5; v++) begin
         drive(1'b1, vt[v].op, vt[v].cnt);
         chk("vec_ready", in_ready, 1);
         tick();
         drive(1'b0, 2'b00, 4'd0);
         chk("vec_nobypass", busy, 0);
         for (int c = 0; c <= int'(vt[v].cnt); c++) begin
            tick();
            chk("vec_j", J, vt[v].ej);
            chk("vec_k", K, vt[v].ek);
            chk("vec_busy", busy, 1);
            chk("vec_done", cmd_done, (c == int'(vt[v].cnt)));
         end
         tick();
         chk("vec_tail", {J, K, busy, cmd_done}, 0);
      end

      // Fill the FIFO behind a long toggle; 5th push refused; drain without bubbles
      fc[0] = '{op: 2'b10, cnt: 4'd1};
      fc[1] = '{op: 2'b01, cnt: 4'd2};
      fc[2] = '{op: 2'b11, cnt: 4'd0};
      fc[3] = '{op: 2'b00, cnt: 4'd1};
      drive(1'b1, 2'b11, 4'd15);
      tick();
      drive(1'b0, 2'b00, 4'd0);
      tick();
      chk("fill_busy", busy, 1);
      c0 = cyc;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, fc[k].op, fc[k].cnt);
         chk("fill_ready", in_ready, 1);
         tick();
      end
      chk("fill_full", in_ready, 0);
      drive(1'b1, 2'b10, 4'd3);
      tick();
      tick();
      chk("fill_refuse", in_ready, 0);
      drive(1'b0, 2'b00, 4'd0);
      for (int t = 0; t < 100 && busy; t++) tick();
      chk("fill_timeout", busy, 0);
      chk("fill_span", cyc - c0, 24);
      tick();
      chk("fill_sb_empty", exp_q.size(), 0);

      // Simultaneous push/pop at three entries, pointers wrap past 2*DEPTH
      drive(1'b1, 2'b11, 4'd5);
      tick();
      drive(1'b1, 2'b01, 4'd0);
      tick();
      chk("wrap_busy", busy, 1);
      drive(1'b1, 2'b10, 4'd0);
      tick();
      drive(1'b1, 2'b11, 4'd0);
      tick();
      drive(1'b0, 2'b00, 4'd0);
      tick();
      tick();
      tick();
      chk("wrap_long_done", cmd_done, 1);
      for (int m = 0; m < 8; m++) begin
         drive(1'b1, 2'(m + 1), 4'd0);
         chk("wrap_ready", in_ready, 1);
         tick();
      end
      drive(1'b0, 2'b00, 4'd0);
      n = 0;
      for (int t = 0; t < 20; t++) begin
         tick();
         if (!busy) break;
         n++;
      end
      chk("wrap_drain", n, 3);
      tick();
      chk("wrap_sb_empty", exp_q.size(), 0);

      // Reset in the middle of a toggle with commands queued behind it
      drive(1'b1, 2'b11, 4'd10);
      tick();
      drive(1'b1, 2'b10, 4'd1);
      tick();
      drive(1'b1, 2'b01, 4'd1);
      tick();
      drive(1'b0, 2'b00, 4'd0);
      tick();
      tick();
      chk("abort_pre_busy", busy, 1);
      reset = 1'b0;
      tick();
      chk("abort_jk", {J, K, busy}, 0);
      chk("abort_ready", in_ready, 0);
      reset = 1'b1;
      for (int t = 0; t < 20; t++) begin
         tick();
         chk("abort_noissue", busy, 0);
      end
      chk("abort_ready_back", in_ready, 1);

`ifdef JK_SEQ_SHADOW_EN
      chk("shadow_clean", mismatch, 0);
      drive(1'b1, 2'b11, 4'd3);
      tick();
      drive(1'b0, 2'b00, 4'd0);
      for (int t = 0; t < 7; t++) begin
         tick();
         chk("shadow_track", q_model, q_fb);
      end
      chk("shadow_nomis", mismatch, 0);
      drive(1'b1, 2'b10, 4'd0);
      tick();
      drive(1'b0, 2'b00, 4'd0);
      tick();
      tick();
      chk("shadow_set", q_model, 1);
      force_low = 1'b1;
      tick();
      chk("shadow_mis", mismatch, 1);
      force_low = 1'b0;
      tick();
      tick();
      chk("shadow_sticky", mismatch, 1);
      reset = 1'b0;
      tick();
      chk("shadow_rst", {q_model, mismatch}, 0);
      reset = 1'b1;
      tick();
`endif

      tick();
      chk("final_sb_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
